// File: rtl/program_loader.sv
// Buffers a host program in a FIFO, then sequences the CPU through reset, instruction load
// and a second reset so execution restarts from PC 0 with the new program in memory.
module program_loader #(
    parameter int DEPTH      = 16,
    parameter int RST_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   Reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            in_data,
    input  logic                   in_last,
    output logic                   CpuReset,
    output logic                   LoadInstructions,
    output logic [31:0]            Instruction,
    output logic [$clog2(DEPTH):0] word_count,
    output logic                   busy,
    output logic                   done,
    output logic                   overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int RW = $clog2(RST_CYCLES) + 1;

    typedef enum logic [1:0] {IDLE, RST1, LOAD, RST2} state_t;

    state_t            state_reg, state_next;
    logic [31:0]       mem [DEPTH];
    logic [AW-1:0]     wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]     level_reg;
    logic [CW-1:0]     word_count_reg, word_count_next;
    logic [RW-1:0]     rst_cnt_reg;
    logic [31:0]       instr_reg;
    logic              overflow_reg, ran_reg, done_reg;
    logic              push, pop, first_word, prog_end, rst_end, fifo_full, fifo_empty;

    assign fifo_empty      = (level_reg == '0);
    assign fifo_full       = (level_reg == CW'(DEPTH));
    assign first_word      = fifo_empty;
    assign rst_end         = (rst_cnt_reg == RW'(RST_CYCLES - 1));
    assign push            = (state_reg == IDLE) && in_valid && !fifo_full;
    assign word_count_next = first_word ? CW'(1) : word_count_reg + CW'(1);
    // A program ends on its marked last word or when it would no longer fit.
    assign prog_end        = push && (in_last || (word_count_next == CW'(DEPTH)));
    // Registered read: the head is fetched on the edge that opens each LOAD cycle.
    assign pop             = ((state_reg == RST1) && rst_end) ||
                             ((state_reg == LOAD) && !fifo_empty);

    // State register
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (prog_end)   state_next = RST1;
            RST1: if (rst_end)    state_next = LOAD;
            LOAD: if (fifo_empty) state_next = RST2;
            RST2: if (rst_end)    state_next = IDLE;
            default:              state_next = IDLE;
        endcase
    end

    // Outputs; the CPU is held in reset in IDLE until a program has been loaded once.
    always_comb begin
        in_ready         = (state_reg == IDLE) && !fifo_full;
        LoadInstructions = (state_reg == LOAD);
        CpuReset         = (state_reg != LOAD) && !((state_reg == IDLE) && ran_reg);
        busy             = (state_reg != IDLE);
        Instruction      = instr_reg;
        word_count       = word_count_reg;
        done             = done_reg;
        overflow         = overflow_reg;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            level_reg      <= '0;
            word_count_reg <= '0;
            rst_cnt_reg    <= '0;
            instr_reg      <= '0;
            overflow_reg   <= 1'b0;
            ran_reg        <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg     <= wr_ptr_reg + AW'(1);
                level_reg      <= level_reg + CW'(1);
                word_count_reg <= word_count_next;
                // Cleared by every word of a program, set only by a truncating one.
                overflow_reg   <= prog_end && !in_last;
            end else if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
                level_reg  <= level_reg - CW'(1);
            end

            if (pop) begin
                instr_reg <= mem[rd_ptr_reg];
            end else begin
                instr_reg <= '0;
            end

            if (((state_reg == RST1) || (state_reg == RST2)) && !rst_end) begin
                rst_cnt_reg <= rst_cnt_reg + RW'(1);
            end else begin
                rst_cnt_reg <= '0;
            end

            done_reg <= (state_reg == RST2) && rst_end;
            if ((state_reg == RST2) && rst_end) begin
                ran_reg <= 1'b1;
            end
        end
    end
endmodule

// File: doc/program_loader.md
# program_loader

Front-end feeder for the pipelined CPU's instruction-load port. It accepts a program as a stream of 32-bit words over a valid/ready handshake and buffers it in a FIFO. It then drives the CPU's `Reset`, `LoadInstructions` and `Instruction` inputs so the words land in instruction memory at addresses 0..N-1, and finally restarts the CPU from PC 0. It sits between the test/host interface and the CPU's load-side inputs.

## Interface
- `DEPTH`, 16: FIFO capacity in words; maximum program length; power of 2, ≥2.
- `RST_CYCLES`, 2: cycles `CpuReset` is held in each reset phase; ≥1.

- `clk`  in  1  single clock; all state on rising edge.
- `Reset`  in  1  asynchronous, active-low reset; clears all state and the FIFO.
- `in_valid`  in  1  host word valid.
- `in_ready`  out  1  loader accepts word; transfer when `in_valid & in_ready`.
- `in_data`  in  32  program word.
- `in_last`  in  1  marks final word of program.
- `CpuReset`  out  1  active-high reset to CPU (drives CPU `Reset`).
- `LoadInstructions`  out  1  CPU load enable.
- `Instruction`  out  32  word presented to CPU instruction memory.
- `word_count`  out  $clog2(DEPTH)+1  words in last accepted program.
- `busy`  out  1  high in any state except IDLE.
- `done`  out  1  one-cycle pulse on load completion.
- `overflow`  out  1  sticky; program truncated at DEPTH words.

## Operation
- States: IDLE → RST1 → LOAD → RST2 → IDLE.
- IDLE: `in_ready = 1` while FIFO not full. Each accepted word is pushed. The first word of a program clears `overflow` and sets the count to 1; later words increment it.
- Transition to RST1 occurs when `in_last` is accepted, or when the DEPTH-th word is accepted with `in_last = 0`. In the second case `overflow` is set.
- RST1: `CpuReset = 1` for RST_CYCLES cycles; `in_ready = 0`. This zeroes the CPU load-address counter.
- LOAD: `LoadInstructions = 1` and `Instruction` = FIFO head, popping one word per cycle for exactly `word_count` consecutive cycles. `CpuReset = 0`.
- RST2: `LoadInstructions = 0`, `Instruction = 0`, `CpuReset = 1` for RST_CYCLES cycles. This zeroes the PC.
- Return to IDLE: `CpuReset = 0` (the CPU runs) and `done` pulses for that first IDLE cycle.
- `in_ready = 0` in RST1, LOAD and RST2. `in_valid` in those states is ignored and is not a transfer.
- Words beyond the truncation point of an overflowed program are accepted in the following IDLE as the start of a new program. The host must not rely on that content.
- FIFO: circular buffer with pointers wrapping modulo DEPTH. It is empty after every LOAD.
- While in IDLE, `word_count` holds the previous program's value until the next program's first word is accepted.

## Timing
- Reset values (asynchronous): state IDLE, FIFO empty, `in_ready = 1`, `CpuReset = 1`, `LoadInstructions = 0`, `Instruction = 0`, `word_count = 0`, `busy = 0`, `done = 0`, `overflow = 0`.
- After reset, `CpuReset` stays 1 through IDLE until the first completed load. The CPU never runs without a program.
- For a last word accepted at edge t:
  - RST1 occupies cycles t+1 .. t+RST_CYCLES.
  - LOAD occupies cycles t+RST_CYCLES+1 .. t+RST_CYCLES+N.
  - RST2 occupies the next RST_CYCLES cycles.
  - `done` is high for the single cycle after that.
- Total latency from last-word edge to `done` is 2·RST_CYCLES+N+1 cycles.
- `Instruction` is registered; word k is valid for the whole k-th LOAD cycle (k = 0..N-1).
- Reset asserted mid-sequence aborts immediately:
  - FIFO is discarded.
  - `LoadInstructions` drops asynchronously.
  - `CpuReset = 1`.
- A full FIFO in IDLE can only coincide with the transition to RST1, so the loader never back-pressures mid-program.

## Test plan
- Reset → `CpuReset = 1`, `in_ready = 1`, `busy = 0`; after 5 idle cycles still `CpuReset = 1`.
- 3 words 0x20010005, 0x20020007, 0x00221820 with last on word 3, RST_CYCLES=2 → `CpuReset` high 2 cycles, then `LoadInstructions` high exactly 3 cycles carrying those words in order, `CpuReset` high 2 cycles, `done` pulse 8 cycles after last-word edge, `word_count = 3`.
- 16 words with no `in_last` (DEPTH=16) → `overflow = 1` after the 16th, load of 16 words, `in_ready = 0` during the sequence. A next program's first word clears `overflow`.
- Single word with `in_last` → `LoadInstructions` high exactly 1 cycle, `word_count = 1`.
- `in_valid` held high with 0xDEADBEEF during LOAD → no transfer, FIFO empty on return to IDLE, no extra load cycle.
- Reset pulsed in the 2nd LOAD cycle of a 4-word program → `LoadInstructions = 0` immediately, `CpuReset = 1`, FIFO empty, no `done`. A fresh 2-word load afterwards completes normally.
